// File: rtl/ascon_perm_ctrl.sv
// Control FSM for one ASCON-128 encryption over permutation_v3.
// Sequences init, AD, PT and finalisation; issues round/enable/select/XOR strobes.
module ascon_perm_ctrl #(
    parameter int NB_W     = 8,
    parameter int PB_START = 6
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [NB_W-1:0] nb_ad_i,
    input  logic [NB_W-1:0] nb_pt_i,
    input  logic            data_valid_i,
    output logic            data_ack_o,
    output logic [3:0]      round_o,
    output logic            enable_o,
    output logic            select_o,
    output logic            xor_data_begin_o,
    output logic            xor_key_begin_o,
    output logic            xor_key_end_o,
    output logic            xor_ext_end_o,
    output logic            cipher_valid_o,
    output logic            tag_valid_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD,
        S_PT,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0]      RND_PB   = 4'(PB_START);
    localparam logic [3:0]      RND_LAST = 4'd11;
    localparam logic [NB_W-1:0] CNT_ONE  = NB_W'(1);
    localparam logic [NB_W-1:0] CNT_ZERO = '0;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_round;
    logic [3:0]      w_round_nxt;
    logic [NB_W-1:0] r_cnt_ad;
    logic [NB_W-1:0] w_cnt_ad_nxt;
    logic [NB_W-1:0] r_cnt_pt;
    logic [NB_W-1:0] w_cnt_pt_nxt;
    logic [3:0]      w_pt_entry;
    logic            w_is_pb;
    logic            w_is_last;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_round  <= 4'd0;
            r_cnt_ad <= '0;
            r_cnt_pt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_round  <= w_round_nxt;
            r_cnt_ad <= w_cnt_ad_nxt;
            r_cnt_pt <= w_cnt_pt_nxt;
        end
    end

    // A lone remaining PT block skips the pb run and enters at round 0.
    assign w_pt_entry = (r_cnt_pt == CNT_ONE) ? 4'd0 : RND_PB;
    assign w_is_pb    = (r_round == RND_PB);
    assign w_is_last  = (r_round == RND_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_round_nxt      = r_round;
        w_cnt_ad_nxt     = r_cnt_ad;
        w_cnt_pt_nxt     = r_cnt_pt;
        data_ack_o       = 1'b0;
        round_o          = r_round;
        enable_o         = 1'b0;
        select_o         = 1'b0;
        xor_data_begin_o = 1'b0;
        xor_key_begin_o  = 1'b0;
        xor_key_end_o    = 1'b0;
        xor_ext_end_o    = 1'b0;
        cipher_valid_o   = 1'b0;
        tag_valid_o      = 1'b0;
        busy_o           = (r_state != S_IDLE);

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt  = S_INIT;
                    w_round_nxt  = 4'd0;
                    w_cnt_ad_nxt = nb_ad_i;
                    w_cnt_pt_nxt = (nb_pt_i == CNT_ZERO) ? CNT_ONE : nb_pt_i;
                end
            end

            S_INIT: begin
                enable_o = 1'b1;
                select_o = (r_round != 4'd0);
                if (w_is_last) begin
                    xor_key_end_o = 1'b1;
                    xor_ext_end_o = (r_cnt_ad == CNT_ZERO);
                    if (r_cnt_ad != CNT_ZERO) begin
                        w_state_nxt = S_AD;
                        w_round_nxt = RND_PB;
                    end else begin
                        w_state_nxt = S_PT;
                        w_round_nxt = w_pt_entry;
                    end
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end

            S_AD: begin
                select_o = 1'b1;
                if (!(w_is_pb && !data_valid_i)) begin
                    enable_o = 1'b1;
                    if (w_is_pb) begin
                        xor_data_begin_o = 1'b1;
                        data_ack_o       = 1'b1;
                        w_cnt_ad_nxt     = r_cnt_ad - CNT_ONE;
                    end
                    if (w_is_last) begin
                        if (r_cnt_ad == CNT_ZERO) begin
                            xor_ext_end_o = 1'b1;
                            w_state_nxt   = S_PT;
                            w_round_nxt   = w_pt_entry;
                        end else begin
                            w_round_nxt = RND_PB;
                        end
                    end else begin
                        w_round_nxt = r_round + 4'd1;
                    end
                end
            end

            S_PT: begin
                select_o = 1'b1;
                if (r_round == 4'd0) begin
                    // Final block: its accept cycle is round 0 of the pa run.
                    if (data_valid_i) begin
                        enable_o         = 1'b1;
                        xor_data_begin_o = 1'b1;
                        xor_key_begin_o  = 1'b1;
                        data_ack_o       = 1'b1;
                        cipher_valid_o   = 1'b1;
                        w_cnt_pt_nxt     = r_cnt_pt - CNT_ONE;
                        w_state_nxt      = S_FINAL;
                        w_round_nxt      = 4'd1;
                    end
                end else if (!(w_is_pb && !data_valid_i)) begin
                    enable_o = 1'b1;
                    if (w_is_pb) begin
                        xor_data_begin_o = 1'b1;
                        data_ack_o       = 1'b1;
                        cipher_valid_o   = 1'b1;
                        w_cnt_pt_nxt     = r_cnt_pt - CNT_ONE;
                    end
                    if (w_is_last) begin
                        w_round_nxt = w_pt_entry;
                    end else begin
                        w_round_nxt = r_round + 4'd1;
                    end
                end
            end

            S_FINAL: begin
                enable_o = 1'b1;
                select_o = 1'b1;
                if (w_is_last) begin
                    xor_key_end_o = 1'b1;
                    w_state_nxt   = S_DONE;
                    w_round_nxt   = 4'd0;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end

            S_DONE: begin
                tag_valid_o = 1'b1;
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
            end
        endcase

        // Silence the datapath as soon as reset is seen.
        if (reset_i) begin
            data_ack_o       = 1'b0;
            round_o          = 4'd0;
            enable_o         = 1'b0;
            select_o         = 1'b0;
            xor_data_begin_o = 1'b0;
            xor_key_begin_o  = 1'b0;
            xor_key_end_o    = 1'b0;
            xor_ext_end_o    = 1'b0;
            cipher_valid_o   = 1'b0;
            tag_valid_o      = 1'b0;
            busy_o           = 1'b0;
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: builds the expected per-cycle trace from the
// phase/round rules and compares the DUT against it on every cycle.
module tb_ascon_perm_ctrl;

    typedef struct packed {
        logic       busy;
        logic       tag;
        logic       cv;
        logic       xe;
        logic       ke;
        logic       kb;
        logic       db;
        logic       sel;
        logic       en;
        logic       ack;
        logic [3:0] rnd;
        logic       mr;
        logic       ms;
        logic       dv;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [7:0] nb_ad_i;
    logic [7:0] nb_pt_i;
    logic       data_valid_i;
    logic       data_ack_o;
    logic [3:0] round_o;
    logic       enable_o;
    logic       select_o;
    logic       xor_data_begin_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       xor_ext_end_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;

    exp_t q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   tag_seen;
    int   cv_cnt;

    ascon_perm_ctrl #(.NB_W(8), .PB_START(6)) dut (
        .clock_i         (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .nb_ad_i         (nb_ad_i),
        .nb_pt_i         (nb_pt_i),
        .data_valid_i    (data_valid_i),
        .data_ack_o      (data_ack_o),
        .round_o         (round_o),
        .enable_o        (enable_o),
        .select_o        (select_o),
        .xor_data_begin_o(xor_data_begin_o),
        .xor_key_begin_o (xor_key_begin_o),
        .xor_key_end_o   (xor_key_end_o),
        .xor_ext_end_o   (xor_ext_end_o),
        .cipher_valid_o  (cipher_valid_o),
        .tag_valid_o     (tag_valid_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %0d want %0d", nm, cyc, a, e);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e    = '0;
        e.mr = 1'b1;
        e.ms = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk(input int r, input logic en, sel, db, kb,
                                ack, cv, ke, xe);
        exp_t e;
        e      = '0;
        e.rnd  = 4'(r);
        e.en   = en;
        e.sel  = sel;
        e.db   = db;
        e.kb   = kb;
        e.ack  = ack;
        e.cv   = cv;
        e.ke   = ke;
        e.xe   = xe;
        e.busy = 1'b1;
        e.mr   = 1'b1;
        e.ms   = 1'b1;
        e.dv   = 1'b1;
        return e;
    endfunction

    task automatic add_stall(input int r, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e    = mk(r, 0, 1, 0, 0, 0, 0, 0, 0);
            e.ms = 1'b0;
            e.dv = 1'b0;
            q.push_back(e);
        end
    endtask

    // Expected trace: start cycle, pa init, pb per AD/non-final PT block,
    // final block fused into the closing pa, DONE, then one IDLE cycle.
    task automatic build(input int nad, input int npt, input int sblk,
                         input int sn);
        exp_t e;
        int   blk;
        q.delete();
        e    = idle_exp();
        e.dv = 1'b1;
        q.push_back(e);
        for (int r = 0; r < 12; r++)
            q.push_back(mk(r, 1, r != 0, 0, 0, 0, 0, r == 11,
                           r == 11 && nad == 0));
        blk = 0;
        for (int b = 0; b < nad; b++) begin
            add_stall(6, blk == sblk ? sn : 0);
            for (int r = 6; r < 12; r++)
                q.push_back(mk(r, 1, 1, r == 6, 0, r == 6, 0, 0,
                               r == 11 && b == nad - 1));
            blk++;
        end
        for (int k = 0; k < npt - 1; k++) begin
            add_stall(6, blk == sblk ? sn : 0);
            for (int r = 6; r < 12; r++)
                q.push_back(mk(r, 1, 1, r == 6, 0, r == 6, r == 6, 0, 0));
            blk++;
        end
        add_stall(0, blk == sblk ? sn : 0);
        for (int r = 0; r < 12; r++)
            q.push_back(mk(r, 1, 1, r == 0, r == 0, r == 0, r == 0,
                           r == 11, 0));
        e      = '0;
        e.busy = 1'b1;
        e.tag  = 1'b1;
        e.dv   = 1'b1;
        q.push_back(e);
        q.push_back(idle_exp());
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("enable", enable_o, cur.en);
            chk("data_ack", data_ack_o, cur.ack);
            chk("xor_data_begin", xor_data_begin_o, cur.db);
            chk("xor_key_begin", xor_key_begin_o, cur.kb);
            chk("xor_key_end", xor_key_end_o, cur.ke);
            chk("xor_ext_end", xor_ext_end_o, cur.xe);
            chk("cipher_valid", cipher_valid_o, cur.cv);
            chk("tag_valid", tag_valid_o, cur.tag);
            chk("busy", busy_o, cur.busy);
            if (cur.mr) chk("round", round_o, cur.rnd);
            if (cur.ms) chk("select", select_o, cur.sel);
            if (tag_valid_o === 1'b1) tag_seen = cyc;
            if (cipher_valid_o === 1'b1) cv_cnt++;
        end
    end

    task automatic run_case(input int nad, input int npt, input int sblk,
                            input int sn, input int glitch, input int rst_at,
                            input int lit_tag, input int lit_cv);
        int npt_eff;
        int midx;
        npt_eff = (npt == 0) ? 1 : npt;
        build(nad, npt_eff, sblk, sn);
        midx = -1;
        foreach (q[i]) if (q[i].tag) midx = i;
        if (rst_at < 0) chk("model_tag_cycle", midx, lit_tag);
        tag_seen = -1;
        cv_cnt   = 0;
        for (int c = 0; c < q.size(); c++) begin
            if (rst_at >= 0 && c == rst_at) break;
            cyc          = c;
            cur          = q[c];
            cur_valid    = 1'b1;
            start_i      = (c == 0) || (c == glitch);
            nb_ad_i      = (c == 0) ? 8'(nad) : (c == glitch) ? 8'd3 : 8'h5A;
            nb_pt_i      = (c == 0) ? 8'(npt) : (c == glitch) ? 8'd5 : 8'hA5;
            data_valid_i = q[c].dv;
            @(posedge clk);
            #1;
        end
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        if (rst_at >= 0) begin
            cur_valid = 1'b0;
            reset_i   = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            reset_i   = 1'b0;
            cur       = idle_exp();
            cur_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                cyc = rst_at + 2 + c;
                @(posedge clk);
                #1;
            end
            cur_valid = 1'b0;
        end else begin
            cur_valid = 1'b0;
            chk("tag_cycle", tag_seen, lit_tag);
            chk("cipher_valid_count", cv_cnt, lit_cv);
        end
    endtask

    initial begin
        reset_i      = 1'b1;
        start_i      = 1'b0;
        nb_ad_i      = 8'd0;
        nb_pt_i      = 8'd0;
        data_valid_i = 1'b0;
        @(posedge clk);
        #1;
        cur       = idle_exp();
        cur_valid = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        cur_valid = 1'b0;

        build(1, 1, -1, 0);
        chk("pin_enable_1", q[1].en, 1'b1);
        chk("pin_enable_30", q[30].en, 1'b1);
        chk("pin_key_end_12", q[12].ke, 1'b1);
        chk("pin_key_end_30", q[30].ke, 1'b1);
        chk("pin_ext_end_18", q[18].xe, 1'b1);
        chk("pin_cipher_19", q[19].cv, 1'b1);

        run_case(1, 1, -1, 0, -1, 6, 0, 0);
        run_case(1, 1, -1, 0, -1, -1, 31, 1);
        run_case(0, 1, -1, 0, -1, -1, 25, 1);
        run_case(2, 3, -1, 0, -1, -1, 49, 3);
        run_case(1, 1, 0, 4, -1, -1, 35, 1);
        run_case(0, 0, -1, 0, 5, -1, 25, 1);
        run_case(0, 2, 1, 2, -1, -1, 33, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
